// File: rtl/ps2_sender_if.sv
// Byte-stream valid/ready channel feeding the ps2_sender transmit FIFO.
interface ps2_sender_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/ps2_sender.sv
// PS/2 device-side (keyboard) transmitter: FIFO-queued bytes sent as 11-bit odd-parity frames.
// Define PS2_SENDER_INHIBIT_EN to add host_inhibit with abort-and-retransmit behaviour.
module ps2_sender #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned IDLE_GAP   = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  ps2_sender_if.slave                   tx,
`ifdef PS2_SENDER_INHIBIT_EN
  input  logic                          host_inhibit,
`endif
  output logic                          ps2_clk,
  output logic                          ps2_data,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = AW + 1;
  localparam int unsigned CW   = $clog2(CLK_DIV) + 1;
  localparam int unsigned GW   = $clog2(IDLE_GAP) + 1;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLoad  = 3'd1;
  localparam logic [2:0] StBitHi = 3'd2;
  localparam logic [2:0] StBitLo = 3'd3;
  localparam logic [2:0] StGap   = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [CW-1:0]   div_q, div_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [3:0]      idx_q, idx_d;
  logic [10:0]     frame_q, frame_d;
  logic            ps2_clk_q, ps2_clk_d;
  logic            ps2_data_q, ps2_data_d;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;

  logic            push, pop, fifo_empty;
  logic            abort, start_ok, use_retry;
  logic [7:0]      load_byte;

  assign fifo_empty  = (count_q == '0);
  // Ready depends only on the current count, so a full FIFO never sees push and pop together.
  assign tx.tx_ready = (count_q != CntW'(FIFO_DEPTH));
  assign push        = tx.tx_valid && tx.tx_ready;
  assign pop         = (state_q == StLoad) && !use_retry;

`ifdef PS2_SENDER_INHIBIT_EN
  logic       retry_valid_q;
  logic [7:0] retry_q;

  // The stop bit (index 10) is never aborted.
  assign abort     = host_inhibit && ((state_q == StBitHi) || (state_q == StBitLo)) &&
                     (idx_q <= 4'd9);
  assign start_ok  = !host_inhibit && (!fifo_empty || retry_valid_q);
  assign use_retry = retry_valid_q;
  assign load_byte = retry_valid_q ? retry_q : mem[rd_ptr_q];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      retry_valid_q <= 1'b0;
      retry_q       <= '0;
    end else if (abort) begin
      retry_valid_q <= 1'b1;
      retry_q       <= frame_q[8:1];
    end else if (state_q == StLoad) begin
      retry_valid_q <= 1'b0;
    end
  end
`else
  assign abort     = 1'b0;
  assign start_ok  = !fifo_empty;
  assign use_retry = 1'b0;
  assign load_byte = mem[rd_ptr_q];
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    unique case (state_q)
      StIdle: begin
        if (start_ok) state_d = StLoad;
      end
      StLoad: begin
        frame_d = {1'b1, ~^load_byte, load_byte, 1'b0};
        idx_d   = 4'd0;
        state_d = StBitHi;
      end
      StBitHi: begin
        if (abort) begin
          state_d = StGap;
        end else if (div_q == CW'(CLK_DIV - 1)) begin
          state_d = StBitLo;
        end
      end
      StBitLo: begin
        if (abort) begin
          state_d = StGap;
        end else if (div_q == CW'(CLK_DIV - 1)) begin
          if (idx_q == 4'd10) begin
            state_d = StGap;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = StBitHi;
          end
        end
      end
      StGap: begin
        if (gap_q == GW'(IDLE_GAP - 1)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Both counters restart on every state entry, including BIT_LO -> BIT_HI.
    div_d = ((state_q == StBitHi) || (state_q == StBitLo)) ? div_q + CW'(1) : '0;
    gap_d = (state_q == StGap) ? gap_q + GW'(1) : '0;
    if (state_d != state_q) begin
      div_d = '0;
      gap_d = '0;
    end

    ps2_clk_d  = (state_d != StBitLo);
    ps2_data_d = ((state_d == StBitHi) || (state_d == StBitLo)) ? frame_d[idx_d] : 1'b1;
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      div_q      <= '0;
      gap_q      <= '0;
      idx_q      <= '0;
      frame_q    <= '1;
      ps2_clk_q  <= 1'b1;
      ps2_data_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      gap_q      <= gap_d;
      idx_q      <= idx_d;
      frame_q    <= frame_d;
      ps2_clk_q  <= ps2_clk_d;
      ps2_data_q <= ps2_data_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= tx.tx_data;
  end

  assign ps2_clk    = ps2_clk_q;
  assign ps2_data   = ps2_data_q;
  assign busy       = (state_q != StIdle);
  assign fifo_count = count_q;

endmodule
